// File: rtl/alib_fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alib_fifo_arb_pkg
// Purpose  : Shared types and round-robin pick helper for the FIFO arbiters.
// Revision : 1.0 - initial release
// ============================================================================
package alib_fifo_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned c_max_req = 16;

   typedef struct packed {
      logic       any;
      logic [3:0] idx;
   } rr_pick_t;

   // First set bit of valid scanning ptr, ptr+1, ... modulo num_req (ptr < num_req).
   function automatic rr_pick_t rr_pick(
      input logic [c_max_req-1:0] valid,
      input logic [3:0]           ptr,
      input int unsigned          num_req
   );
      rr_pick_t    res;
      int unsigned pos;
      res = '0;
      for (int unsigned k = 0; k < c_max_req; k++) begin
         pos = {28'd0, ptr} + k;
         if (pos >= num_req) begin
            pos = pos - num_req;
         end
         if ((k < num_req) && !res.any && valid[pos[3:0]]) begin
            res.any = 1'b1;
            res.idx = pos[3:0];
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alib_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : alib_rr_picker
// Purpose  : Combinational rotating-priority picker over NUM_REQ requests.
// Revision : 1.0 - initial release
// ============================================================================
module alib_rr_picker
   import alib_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic                       any,
   output logic [$clog2(NUM_REQ)-1:0] idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [c_max_req-1:0] w_req_ext;
   logic [3:0]           w_ptr_ext;
   rr_pick_t             w_pick;

   always_comb begin
      w_req_ext = c_max_req'(req);
      w_ptr_ext = 4'(ptr);
      w_pick    = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
      any       = w_pick.any;
      idx       = w_pick.idx[IDX_W-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/alib_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alib_fifo_rr_arbiter
// Purpose  : Round-robin burst arbiter feeding one circular-FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
module alib_fifo_rr_arbiter
   import alib_fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       fifo_full,
   output logic                       fifo_wr_en,
   output logic [WIDTH-1:0]           fifo_data,
   output logic                       grant_valid,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_REQ - 1);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [IDX_W-1:0] r_grant_id;
   logic [IDX_W-1:0] w_grant_id_nxt;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] w_rr_ptr_nxt;
   logic [CNT_W-1:0] r_beat_cnt;
   logic [CNT_W-1:0] w_beat_cnt_nxt;

   logic             w_pick_any;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_owner_valid;
   logic             w_accept;
   logic [IDX_W-1:0] w_after_owner;

   alib_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req (req_valid),
      .ptr (r_rr_ptr),
      .any (w_pick_any),
      .idx (w_pick_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ARB_IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   // Outputs stay combinational so the accept and the FIFO's !full gate always agree.
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_id_nxt = r_grant_id;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_beat_cnt_nxt = r_beat_cnt;
      req_ready      = '0;
      fifo_wr_en     = 1'b0;
      fifo_data      = '0;

      w_owner_valid  = req_valid[r_grant_id];
      w_accept       = (r_state == ARB_GRANT) && w_owner_valid && !fifo_full;
      w_after_owner  = (r_grant_id == c_last_idx) ? '0 : r_grant_id + 1'b1;

      case (r_state)
         ARB_IDLE: begin
            if (w_pick_any) begin
               w_state_nxt    = ARB_GRANT;
               w_grant_id_nxt = w_pick_idx;
               w_beat_cnt_nxt = '0;
            end
         end
         ARB_GRANT: begin
            req_ready[r_grant_id] = !fifo_full;
            fifo_wr_en            = w_accept;
            fifo_data             = req_data[r_grant_id*WIDTH +: WIDTH];
            if (!w_owner_valid || (w_accept && (r_beat_cnt == c_last_beat))) begin
               w_state_nxt  = ARB_IDLE;
               w_rr_ptr_nxt = w_after_owner;
            end else if (w_accept) begin
               w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   assign grant_valid = (r_state == ARB_GRANT);
   assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_alib_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alib_fifo_rr_arbiter
// Purpose  : Scoreboard bench for the round-robin FIFO write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alib_fifo_rr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ*WIDTH-1:0] req_data = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     fifo_full = 1'b0;
   logic                     fifo_wr_en;
   logic [WIDTH-1:0]         fifo_data;
   logic                     grant_valid;
   logic [1:0]               grant_id;

   int total = 0;
   int bad   = 0;

   logic [7:0]  pq[NUM_REQ][$];
   int          sent[NUM_REQ];
   logic [11:0] exp_w[$];
   int          exp_gid[$];
   int          exp_len[$];
   logic        prev_gv = 1'b0;
   int          beats = 0;

   always #5 clk = ~clk;

   alib_fifo_rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_data   (fifo_data),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic miss(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %0h, required nothing (queue empty)", name, act);
   endtask

   // Monitor: grant starts, FIFO writes and grant ends are checked against the queues.
   always @(negedge clk) begin
      if (grant_valid && !prev_gv) begin
         beats = 0;
         if (exp_gid.size() == 0) miss("grant_extra", 32'(grant_id));
         else chk("grant_id", 32'(grant_id), 32'(exp_gid.pop_front()));
      end
      if (fifo_wr_en) begin
         beats++;
         if (exp_w.size() == 0) miss("write_extra", {20'd0, 2'b00, grant_id, fifo_data});
         else chk("fifo_write", {20'd0, 2'b00, grant_id, fifo_data}, {20'd0, exp_w.pop_front()});
      end
      if (!grant_valid && prev_gv) begin
         if (exp_len.size() == 0) miss("burst_extra", 32'(beats));
         else chk("burst_len", 32'(beats), 32'(exp_len.pop_front()));
      end
      prev_gv = grant_valid;
   end

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (pq[i].size() > 0);
         req_data[i*WIDTH +: WIDTH] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
      end
   endtask

   task automatic step();
      logic [NUM_REQ-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc[i] && (pq[i].size() > 0)) begin
            void'(pq[i].pop_front());
            sent[i]++;
         end
      end
      drive();
   endtask

   task automatic load(input int p, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) pq[p].push_back(base + 8'(k));
   endtask

   task automatic expw(input int p, input logic [7:0] d);
      exp_w.push_back({4'(p), d});
   endtask

   function automatic logic all_done();
      logic d;
      d = (exp_w.size() == 0) && (exp_gid.size() == 0) && (exp_len.size() == 0) && !grant_valid;
      for (int i = 0; i < NUM_REQ; i++) d = d && (pq[i].size() == 0);
      return d;
   endfunction

   task automatic run(input string name, input int budget);
      for (int c = 0; c < budget; c++) begin
         if (all_done()) break;
         step();
      end
      chk(name, 32'(all_done()), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      fifo_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pq[i].delete();
         sent[i] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      bit found;
      for (int i = 0; i < NUM_REQ; i++) sent[i] = 0;
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant_valid", 32'(grant_valid), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_fifo_data", 32'(fifo_data), 32'd0);
      chk("rst_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Producer 2 alone, 10 beats: bursts of 4, 4, 2.
      load(2, 10, 8'h20);
      for (int k = 0; k < 10; k++) expw(2, 8'h20 + 8'(k));
      exp_gid.push_back(2); exp_gid.push_back(2); exp_gid.push_back(2);
      exp_len.push_back(4); exp_len.push_back(4); exp_len.push_back(2);
      drive();
      #1;
      chk("t1_latency_idle", 32'(grant_valid), 32'd0);
      step();
      #1;
      chk("t1_latency_grant", 32'(grant_valid), 32'd1);
      chk("t1_latency_ready", 32'(req_ready), 32'h4);
      run("t1_drain", 60);

      // All four producers valid from reset: 0,1,2,3,0,1,2,3.
      do_reset();
      for (int p = 0; p < NUM_REQ; p++) load(p, 8, 8'(p * 16));
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NUM_REQ; p++) begin
            exp_gid.push_back(p);
            exp_len.push_back(4);
            for (int k = r * 4; k < r * 4 + 4; k++) expw(p, 8'(p * 16) + 8'(k));
         end
      end
      drive();
      run("t2_drain", 200);

      // FIFO full for 5 cycles after beat 2.
      do_reset();
      load(0, 4, 8'h30);
      for (int k = 0; k < 4; k++) expw(0, 8'h30 + 8'(k));
      exp_gid.push_back(0);
      exp_len.push_back(4);
      drive();
      for (int c = 0; c < 20; c++) begin
         if (sent[0] >= 2) break;
         step();
      end
      chk("t3_two_beats", 32'(sent[0]), 32'd2);
      fifo_full = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t3_full_wr_en", 32'(fifo_wr_en), 32'd0);
         chk("t3_full_ready", 32'(req_ready), 32'd0);
         chk("t3_beat_hold", 32'(dut.r_beat_cnt), 32'd2);
         chk("t3_grant_hold", 32'(grant_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      fifo_full = 1'b0;
      run("t3_drain", 40);

      // Producer 1 drops after one beat; producer 2 takes over.
      do_reset();
      load(1, 1, 8'h41);
      load(2, 3, 8'h50);
      expw(1, 8'h41);
      for (int k = 0; k < 3; k++) expw(2, 8'h50 + 8'(k));
      exp_gid.push_back(1); exp_gid.push_back(2);
      exp_len.push_back(1); exp_len.push_back(3);
      drive();
      found = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (grant_valid && (grant_id == 2'd2)) begin
            found = 1'b1;
            break;
         end
      end
      chk("t4_grant2_seen", 32'(found), 32'd1);
      chk("t4_rr_ptr", 32'(dut.r_rr_ptr), 32'd2);
      run("t4_drain", 40);

      // Asynchronous reset pulse mid-burst.
      do_reset();
      load(0, 8, 8'h60);
      expw(0, 8'h60); expw(0, 8'h61);
      exp_gid.push_back(0);
      exp_len.push_back(2);
      drive();
      for (int c = 0; c < 20; c++) begin
         if (sent[0] >= 2) break;
         step();
      end
      chk("t5_two_beats", 32'(sent[0]), 32'd2);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("t5_rst_ready", 32'(req_ready), 32'd0);
      chk("t5_rst_grant", 32'(grant_valid), 32'd0);
      chk("t5_rst_data", 32'(fifo_data), 32'd0);
      chk("t5_rst_grant_id", 32'(grant_id), 32'd0);
      pq[0].delete();
      sent[0] = 0;
      load(2, 4, 8'h70);
      load(3, 4, 8'h80);
      for (int k = 0; k < 4; k++) expw(2, 8'h70 + 8'(k));
      for (int k = 0; k < 4; k++) expw(3, 8'h80 + 8'(k));
      exp_gid.push_back(2); exp_gid.push_back(3);
      exp_len.push_back(4); exp_len.push_back(4);
      drive();
      #4;
      rst = 1'b1;
      run("t5_drain", 60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
